trail_stack: RTL and testbench
==============================

# trail_stack

Parametrised assignment-trail stack for the DPLL solver core, successor to the fixed 9-bit push/pop trace table. Records every variable assignment (decided or forced) in order. Adds full detection, a decision-level count, and a hardware backtrack operation. Backtrack unwinds to the most recent decision, streams each popped entry to the variable-state table, then re-pushes the decided variable inverted as forced. Sits between the decision/BCP controller and the variable-state table.

## Interface
- VAR_W, 9, width of variable index
- DEPTH, 512, stack entries (power of two, ≥ 2)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- en  in  1  operation strobe, sampled when busy = 0
- op  in  2  00 pop, 01 push, 10 backtrack, 11 reserved (ignored)
- type_in  in  1  0 Decide, 1 Forced
- val_in  in  1  assigned value
- variable_in  in  VAR_W  variable index
- out_valid  out  1  type_out/val_out/variable_out valid this cycle
- type_out, val_out  out  1 each  popped entry fields
- variable_out  out  VAR_W  popped entry variable
- busy  out  1  backtrack in progress
- bt_done  out  1  one-cycle pulse at backtrack end
- empty, full  out  1 each  occupancy flags
- unsat  out  1  sticky: backtrack found no decision
- dlevel  out  $clog2(DEPTH+1)  Decide entries currently held

## Operation
- FSM states: IDLE, UNWIND, FLIP.
- IDLE, en = 1, push, not full: write entry at sp; sp += 1; if type_in = 0, dlevel += 1.
- IDLE, en = 1, pop, not empty: sp -= 1; entry at sp-1 presented; if it is a Decide entry, dlevel -= 1.
- IDLE, en = 1, backtrack: go to UNWIND.
  - If empty, instead set unsat and pulse bt_done; stay IDLE.
- UNWIND: pops one entry per cycle, each presented with out_valid.
  - Popped entry Decide: latch it; go to FLIP.
  - Popped entry Forced and stack now empty: set unsat, pulse bt_done, go to IDLE.
- FLIP: push {Forced, ~latched val, latched variable}; pulse bt_done; go to IDLE. dlevel net −1 vs pre-backtrack.
- Boundary rules:
  - Push when full: ignored, no state change.
  - Pop when empty: ignored, out_valid stays 0.
  - op = 11: ignored.
  - en while busy: ignored.
- sp has width $clog2(DEPTH+1); full = (sp == DEPTH), empty = (sp == 0).
- Reset mid-backtrack: abandons the operation; all state cleared.

## Timing
- Reset values: sp = 0, dlevel = 0, FSM = IDLE, empty = 1.
  - full, busy, out_valid, bt_done, unsat: 0.
  - type_out, val_out, variable_out: 0.
- Push: visible in empty/full/dlevel in the cycle after the strobe.
- Pop: out_valid and data appear in the cycle after the strobe, for one cycle (registered memory read).
- Backtrack over k Forced entries above the top decision:
  - busy high from cycle after strobe for k+2 cycles.
  - out_valid high for k+1 consecutive cycles.
  - bt_done coincides with the FLIP cycle.
- Back-to-back push/pop in consecutive cycles supported; pop immediately after push returns the pushed entry.

## Configuration
- TRAIL_STACK_DLEVEL_EN defined: dlevel counter implemented as above.
- Not defined: counter removed, dlevel tied to 0.
  - Backtrack still locates the decision by scanning type bits.
  - All other behaviour identical.

## Structure
- Package trail_pkg:
  - op encodings as enum: OP_POP, OP_PUSH, OP_BT.
  - TYPE_DECIDE = 0, TYPE_FORCED = 1.
  - trail_entry_t struct {type, val, variable}, parametrised via VAR_W default.
  - FSM state enum.
- Sub-module trail_mem: single-port, synchronous-write, registered-read RAM of DEPTH × (VAR_W+2).
- Top level holds sp, dlevel, FSM, and flags.

## Test plan
- Reset, then idle: empty = 1, full = 0, dlevel = 0, out_valid = 0, unsat = 0.
- Push (D,1,5), (F,0,7), (F,1,9); pop ×3:
  - Outputs 9/1/F, then 7/0/F, then 5/1/D, each one cycle after its strobe.
  - empty = 1 after the third pop; dlevel ends 0.
- Push (D,1,3), (F,0,4), (F,1,6); backtrack:
  - busy for 4 cycles.
  - out_valid streams 6, 4, 3.
  - bt_done on cycle 4.
  - Stack then holds a single (F,0,3); dlevel = 0.
- Push two Forced entries, backtrack: streams both, unsat = 1, bt_done pulses, empty = 1. unsat stays 1 until reset.
- DEPTH = 4: push 5 entries: full = 1 after the 4th, 5th ignored; pop on empty ignored.
- Assert reset during UNWIND: next cycle busy = 0, empty = 1, dlevel = 0; subsequent push works.

Source files
------------

// File: rtl/trail_pkg.sv
// Shared types for the DPLL assignment-trail stack: op codes, entry layout, FSM states.
package trail_pkg;

   typedef enum logic [1:0] {
      OP_POP  = 2'b00,
      OP_PUSH = 2'b01,
      OP_BT   = 2'b10
   } op_e;

   localparam logic TYPE_DECIDE = 1'b0;
   localparam logic TYPE_FORCED = 1'b1;

   localparam int TRAIL_VAR_W = 9;

   typedef struct packed {
      logic                   etype;
      logic                   val;
      logic [TRAIL_VAR_W-1:0] variable;
   } trail_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      UNWIND,
      FLIP
   } state_e;

endpackage

// File: rtl/trail_mem.sv
// Single-port trail RAM: synchronous write, registered read that only updates on re.
module trail_mem #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic             re,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
   end

   // Read register is reset so the popped-entry outputs start at zero.
   always_ff @(posedge clock) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/trail_stack.sv
// Assignment-trail stack with pop/push/backtrack; decision-level counter present
// only when TRAIL_STACK_DLEVEL_EN is defined (otherwise dlevel reads 0).
module trail_stack
   import trail_pkg::*;
#(
   parameter int VAR_W = 9,
   parameter int DEPTH = 512
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       en,
   input  logic [1:0]                 op,
   input  logic                       type_in,
   input  logic                       val_in,
   input  logic [VAR_W-1:0]           variable_in,
   output logic                       out_valid,
   output logic                       type_out,
   output logic                       val_out,
   output logic [VAR_W-1:0]           variable_out,
   output logic                       busy,
   output logic                       bt_done,
   output logic                       empty,
   output logic                       full,
   output logic                       unsat,
   output logic [$clog2(DEPTH+1)-1:0] dlevel
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = $clog2(DEPTH+1);
   localparam int EW  = VAR_W + 2;

   state_e             state;
   logic [SPW-1:0]     sp;
   logic               latched_val;
   logic [VAR_W-1:0]   latched_var;

   logic               mem_we;
   logic               mem_re;
   logic [AW-1:0]      mem_addr;
   logic [EW-1:0]      mem_wdata;
   logic [EW-1:0]      mem_rdata;

   assign empty        = (sp == '0);
   assign full         = (sp == SPW'(DEPTH));
   assign type_out     = mem_rdata[EW-1];
   assign val_out      = mem_rdata[EW-2];
   assign variable_out = mem_rdata[VAR_W-1:0];

   trail_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock (clock),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // The first entry is popped on the backtrack strobe itself, so each UNWIND
   // cycle inspects an already-presented entry; this gives busy = k+2 cycles.
   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = AW'(sp);
      mem_wdata = {type_in, val_in, variable_in};
      unique case (state)
         IDLE: begin
            if (en) begin
               if (op == OP_PUSH && !full) begin
                  mem_we = 1'b1;
               end else if ((op == OP_POP || op == OP_BT) && !empty) begin
                  mem_re   = 1'b1;
                  mem_addr = AW'(sp - 1'b1);
               end
            end
         end
         UNWIND: begin
            if (type_out != TYPE_DECIDE && !empty) begin
               mem_re   = 1'b1;
               mem_addr = AW'(sp - 1'b1);
            end
         end
         FLIP: begin
            mem_we    = 1'b1;
            mem_wdata = {TYPE_FORCED, ~latched_val, latched_var};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         sp          <= '0;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         bt_done     <= 1'b0;
         unsat       <= 1'b0;
         latched_val <= 1'b0;
         latched_var <= '0;
      end else begin
         out_valid <= 1'b0;
         bt_done   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (en) begin
                  case (op)
                     OP_PUSH: if (!full) sp <= sp + 1'b1;
                     OP_POP: begin
                        if (!empty) begin
                           sp        <= sp - 1'b1;
                           out_valid <= 1'b1;
                        end
                     end
                     OP_BT: begin
                        if (empty) begin
                           unsat   <= 1'b1;
                           bt_done <= 1'b1;
                        end else begin
                           sp        <= sp - 1'b1;
                           out_valid <= 1'b1;
                           busy      <= 1'b1;
                           state     <= UNWIND;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            UNWIND: begin
               if (type_out == TYPE_DECIDE) begin
                  latched_val <= val_out;
                  latched_var <= variable_out;
                  bt_done     <= 1'b1;
                  state       <= FLIP;
               end else if (empty) begin
                  unsat   <= 1'b1;
                  bt_done <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  sp        <= sp - 1'b1;
                  out_valid <= 1'b1;
               end
            end
            FLIP: begin
               sp    <= sp + 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef TRAIL_STACK_DLEVEL_EN
   logic dl_inc;
   logic dl_dec;

   // Decrement when a Decide entry is presented, covering both pops and backtrack.
   always_comb begin
      dl_inc = (state == IDLE) && en && (op == OP_PUSH) && !full && (type_in == TYPE_DECIDE);
      dl_dec = out_valid && (type_out == TYPE_DECIDE);
   end

   always_ff @(posedge clock) begin
      if (reset) dlevel <= '0;
      else       dlevel <= dlevel + SPW'(dl_inc) - SPW'(dl_dec);
   end
`else
   assign dlevel = '0;
`endif

endmodule

// File: tb/tb_trail_stack.sv
// Directed self-checking bench for trail_stack (512-deep and 4-deep instances).
module tb_trail_stack;

   logic       clock;
   logic       reset;
   logic       en;
   logic [1:0] op;
   logic       type_in;
   logic       val_in;
   logic [8:0] variable_in;

   logic       out_valid, type_out, val_out, busy, bt_done, empty, full, unsat;
   logic [8:0] variable_out;
   logic [9:0] dlevel;

   logic       out_valid_b, type_out_b, val_out_b, busy_b, bt_done_b, empty_b, full_b, unsat_b;
   logic [8:0] variable_out_b;
   logic [2:0] dlevel_b;

   int n_tests = 0;
   int n_fail  = 0;

   trail_stack #(.VAR_W(9), .DEPTH(512)) dut (
      .clock(clock), .reset(reset), .en(en), .op(op), .type_in(type_in),
      .val_in(val_in), .variable_in(variable_in), .out_valid(out_valid),
      .type_out(type_out), .val_out(val_out), .variable_out(variable_out),
      .busy(busy), .bt_done(bt_done), .empty(empty), .full(full),
      .unsat(unsat), .dlevel(dlevel)
   );

   trail_stack #(.VAR_W(9), .DEPTH(4)) dut_b (
      .clock(clock), .reset(reset), .en(en), .op(op), .type_in(type_in),
      .val_in(val_in), .variable_in(variable_in), .out_valid(out_valid_b),
      .type_out(type_out_b), .val_out(val_out_b), .variable_out(variable_out_b),
      .busy(busy_b), .bt_done(bt_done_b), .empty(empty_b), .full(full_b),
      .unsat(unsat_b), .dlevel(dlevel_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_dl(input int v);
`ifdef TRAIL_STACK_DLEVEL_EN
      return v;
`else
      return (v == 0) ? 0 : 0;
`endif
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_op(input logic [1:0] o, input logic t, input logic v, input logic [8:0] x);
      en = 1'b1; op = o; type_in = t; val_in = v; variable_in = x;
      tick();
      en = 1'b0; op = 2'b00;
   endtask

   // Strobe a backtrack and watch ncyc cycles; optionally strobe pushes while busy.
   task automatic bt_run(input int ncyc, input bit inject, output int busy_n, output int ov_n,
                         output int done_at, output logic [8:0] v0, output logic [8:0] v1,
                         output logic [8:0] v2);
      int k;
      busy_n = 0; ov_n = 0; done_at = 0; k = 0;
      v0 = '0; v1 = '0; v2 = '0;
      do_op(2'b10, 1'b0, 1'b0, 9'd0);
      for (int i = 1; i <= ncyc; i++) begin
         if (busy) busy_n++;
         if (bt_done && done_at == 0) done_at = i;
         if (out_valid) begin
            ov_n++;
            if (k == 0) v0 = variable_out;
            else if (k == 1) v1 = variable_out;
            else if (k == 2) v2 = variable_out;
            k++;
         end
         if (inject && i <= 3) begin
            en = 1'b1; op = 2'b01; type_in = 1'b0; val_in = 1'b1; variable_in = 9'd99;
         end else begin
            en = 1'b0; op = 2'b00;
         end
         tick();
      end
      en = 1'b0;
   endtask

   int         bn, on, da;
   logic [8:0] s0, s1, s2;

   initial begin
      reset = 1'b1; en = 1'b0; op = 2'b00; type_in = 1'b0; val_in = 1'b0; variable_in = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // reset / idle state
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_dlevel", dlevel, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_unsat", unsat, 0);
      check("rst_busy", busy, 0);
      check("rst_var_out", variable_out, 0);

      // push three, reserved op, pop three back-to-back
      do_op(2'b01, 1'b0, 1'b1, 9'd5);
      do_op(2'b01, 1'b1, 1'b0, 9'd7);
      do_op(2'b01, 1'b1, 1'b1, 9'd9);
      check("push_dlevel", dlevel, exp_dl(1));
      check("push_empty", empty, 0);
      do_op(2'b11, 1'b0, 1'b0, 9'd1);
      check("rsv_out_valid", out_valid, 0);
      check("rsv_dlevel", dlevel, exp_dl(1));
      do_op(2'b00, 1'b0, 1'b0, 9'd0);
      check("pop1_valid", out_valid, 1);
      check("pop1", {type_out, val_out, variable_out}, {1'b1, 1'b1, 9'd9});
      do_op(2'b00, 1'b0, 1'b0, 9'd0);
      check("pop2_valid", out_valid, 1);
      check("pop2", {type_out, val_out, variable_out}, {1'b1, 1'b0, 9'd7});
      do_op(2'b00, 1'b0, 1'b0, 9'd0);
      check("pop3_valid", out_valid, 1);
      check("pop3", {type_out, val_out, variable_out}, {1'b0, 1'b1, 9'd5});
      check("pop3_empty", empty, 1);
      tick();
      check("pop_after_valid", out_valid, 0);
      check("pop_dlevel", dlevel, exp_dl(0));

      // backtrack over two Forced entries to a decision, with pushes during busy
      do_op(2'b01, 1'b0, 1'b1, 9'd3);
      do_op(2'b01, 1'b1, 1'b0, 9'd4);
      do_op(2'b01, 1'b1, 1'b1, 9'd6);
      check("bt_pre_dlevel", dlevel, exp_dl(1));
      bt_run(8, 1'b1, bn, on, da, s0, s1, s2);
      check("bt_busy_cycles", bn, 4);
      check("bt_valid_cycles", on, 3);
      check("bt_done_cycle", da, 4);
      check("bt_stream", {s0, s1, s2}, {9'd6, 9'd4, 9'd3});
      check("bt_unsat", unsat, 0);
      check("bt_dlevel", dlevel, exp_dl(0));
      do_op(2'b00, 1'b0, 1'b0, 9'd0);
      check("bt_flip_entry", {out_valid, type_out, val_out, variable_out}, {1'b1, 1'b1, 1'b0, 9'd3});
      check("bt_flip_empty", empty, 1);

      // backtrack with no decision present
      do_op(2'b01, 1'b1, 1'b1, 9'd10);
      do_op(2'b01, 1'b1, 1'b0, 9'd11);
      bt_run(6, 1'b0, bn, on, da, s0, s1, s2);
      check("nodec_busy_cycles", bn, 2);
      check("nodec_valid_cycles", on, 2);
      check("nodec_done_cycle", da, 3);
      check("nodec_stream", {s0, s1}, {9'd11, 9'd10});
      check("nodec_unsat", unsat, 1);
      check("nodec_empty", empty, 1);
      do_op(2'b01, 1'b0, 1'b0, 9'd12);
      tick();
      check("unsat_sticky", unsat, 1);

      // 4-deep instance: full boundary and pop on empty
      reset = 1'b1; tick(); reset = 1'b0;
      check("b_rst_empty", empty_b, 1);
      for (int i = 1; i <= 5; i++) begin
         do_op(2'b01, 1'b1, 1'b0, 9'(i));
         if (i == 3) check("b_full_at3", full_b, 0);
         if (i >= 4) check("b_full", full_b, 1);
      end
      for (int i = 4; i >= 1; i--) begin
         do_op(2'b00, 1'b0, 1'b0, 9'd0);
         check("b_pop", {out_valid_b, variable_out_b}, {1'b1, 9'(i)});
      end
      check("b_empty", empty_b, 1);
      do_op(2'b00, 1'b0, 1'b0, 9'd0);
      check("b_pop_empty_valid", out_valid_b, 0);
      check("b_pop_empty_still", empty_b, 1);

      // reset during UNWIND
      reset = 1'b1; tick(); reset = 1'b0;
      do_op(2'b01, 1'b0, 1'b1, 9'd20);
      do_op(2'b01, 1'b1, 1'b0, 9'd21);
      do_op(2'b01, 1'b1, 1'b1, 9'd22);
      do_op(2'b10, 1'b0, 1'b0, 9'd0);
      check("mid_bt_busy", busy, 1);
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_empty", empty, 1);
      check("rst_mid_dlevel", dlevel, 0);
      check("rst_mid_unsat", unsat, 0);
      do_op(2'b01, 1'b1, 1'b1, 9'd30);
      check("rst_mid_push", empty, 0);
      do_op(2'b00, 1'b0, 1'b0, 9'd0);
      check("rst_mid_pop", {out_valid, variable_out}, {1'b1, 9'd30});

      // backtrack on empty stack
      do_op(2'b10, 1'b0, 1'b0, 9'd0);
      check("bt_empty_done", bt_done, 1);
      check("bt_empty_unsat", unsat, 1);
      check("bt_empty_busy", busy, 0);
      check("bt_empty_valid", out_valid, 0);
      tick();
      check("bt_empty_done_pulse", bt_done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
